stall_flush_sequencer: RTL and testbench
========================================

# stall_flush_sequencer

Pipeline sequencing controller in the ID stage. Turns the per-cycle stall requests from the control-hazard and load-use detectors, the resolved-branch signal and HLT decode into the write enables, flush and bubble controls for the PC, IF/ID and ID/EX registers. It owns multi-cycle stalls: once a 2-cycle stall is granted, the sequencer counts it out itself. It also keeps a saturating stall-cycle performance counter.

## Interface
- CNT_W, 16, width of StallCycles performance counter
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Stall  in  1  control-hazard stall request (combinational, current cycle)
- StallWrite  in  1  with Stall: request is 2 cycles instead of 1
- LoadUseStall  in  1  data-hazard stall request, always 1 cycle
- BranchTaken  in  1  branch in ID resolved taken this cycle
- Hlt  in  1  HLT decoded in ID this cycle
- StatClr  in  1  synchronous clear of StallCycles
- PC_Wr  out  1  PC register write enable
- IFID_Wr  out  1  IF/ID register write enable
- IFID_Flush  out  1  zero IF/ID contents on next edge
- IDEX_Bubble  out  1  load NOP into ID/EX on next edge
- Busy  out  1  stall in progress this cycle
- Halted  out  1  registered, core halted
- StallCycles  out  CNT_W  saturating count of stalled cycles

## Operation
- States: RUN, STALL, HALTED. 1-bit remaining-cycle counter `rem`.
- Reset (rst_n low, asynchronous): state=RUN, rem=0, Halted=0, StallCycles=0. While rst_n is low, outputs are forced to PC_Wr=0, IFID_Wr=0, IFID_Flush=1, IDEX_Bubble=1, Busy=0.
- The outputs are a Mealy function of the state and the current inputs. Request priority in RUN: stall (Stall|LoadUseStall) > BranchTaken > Hlt.
- RUN, no request: PC_Wr=1, IFID_Wr=1, IFID_Flush=0, IDEX_Bubble=0, Busy=0.
- RUN, stall request: PC_Wr=0, IFID_Wr=0, IDEX_Bubble=1, Busy=1, IFID_Flush=0.
  - If Stall&StallWrite: go to STALL with rem=0 (one further cycle).
  - Otherwise stay in RUN; the detector re-evaluates next cycle.
- RUN, BranchTaken with no stall: PC_Wr=1 (loads target), IFID_Wr=1, IFID_Flush=1, IDEX_Bubble=0. Stay in RUN.
- RUN, Hlt with no stall and no branch: PC_Wr=0, IFID_Wr=0, IDEX_Bubble=0 (HLT itself proceeds). Go to HALTED.
- STALL: PC_Wr=0, IFID_Wr=0, IDEX_Bubble=1, Busy=1. All of Stall, LoadUseStall, BranchTaken and Hlt are ignored. When rem==0, go to RUN; otherwise decrement rem.
- HALTED: PC_Wr=0, IFID_Wr=0, IDEX_Bubble=1, IFID_Flush=0, Busy=0, Halted=1. Only reset exits this state; all other inputs are ignored.
- StallCycles: increments by 1 on each edge where Busy=1 was asserted, and saturates at all-ones (no wrap). StatClr has priority over the increment and clears the counter to 0.
- An input at X or Z is treated as deasserted.

## Timing
- Stall, branch and halt controls take effect in the same cycle as the request (no latency). They act on the register loads at the next rising edge.
- A 2-cycle stall is the request cycle plus one STALL cycle, so RUN resumes on the third cycle.
- A 1-cycle stall holds PC and IF/ID for exactly one edge.
- Halted rises on the edge after the Hlt cycle.
- StallCycles reflects a stalled cycle one edge after that cycle.
- Reset asserted mid-STALL or in HALTED: state returns to RUN immediately and asynchronously, and rem is discarded. After rst_n releases, the first edge operates from RUN.
- Same-cycle Stall and BranchTaken: the stall wins, no flush occurs, and the branch is re-presented later by ID.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release. During reset, PC_Wr=0, IFID_Flush=1 and IDEX_Bubble=1. On the first idle cycle after release, PC_Wr=1, IFID_Wr=1 and StallCycles=0.
- Stall=1, StallWrite=1 for one cycle: PC_Wr=0 and IDEX_Bubble=1 for exactly 2 cycles, Busy high for 2 cycles, then RUN resumes and StallCycles=2. Stall=1 held during the STALL cycle does not extend the stall.
- LoadUseStall=1 for 3 consecutive cycles: 3 stalled cycles, state never leaves RUN, StallCycles=3. StatClr=1 on the following edge gives StallCycles=0.
- BranchTaken=1 with Stall=1 in the same cycle: IFID_Flush=0 and PC_Wr=0. On the next cycle, BranchTaken=1 alone: IFID_Flush=1 and PC_Wr=1.
- Hlt=1: PC_Wr=0 in that cycle and Halted=1 after the edge. Later BranchTaken/Stall pulses leave PC_Wr=0 and StallCycles unchanged. Pulsing rst_n low clears Halted asynchronously.
- Force StallCycles toward saturation with CNT_W=4 and 20 stalled cycles: the counter holds at 15.

Source files
------------

// File: rtl/stall_flush_sequencer.sv
// ID-stage pipeline sequencer: turns hazard, branch and halt requests into PC / IF/ID / ID/EX
// controls, counts out granted 2-cycle stalls and keeps a saturating stalled-cycle counter.
module stall_flush_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Stall,
    input  logic             StallWrite,
    input  logic             LoadUseStall,
    input  logic             BranchTaken,
    input  logic             Hlt,
    input  logic             StatClr,
    output logic             PC_Wr,
    output logic             IFID_Wr,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             Busy,
    output logic             Halted,
    output logic [CNT_W-1:0] StallCycles
);

    // state  | meaning
    // RUN    | normal flow; requests are decoded combinationally each cycle
    // STALL  | sequencer-owned stall cycles after a granted 2-cycle stall, rem = cycles left - 1
    // HALTED | core stopped after HLT; only reset leaves
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;
    logic   rem;

    // Inputs at X/Z must read as deasserted, so only a clean 1 counts.
    logic stall_req, two_cycle, branch_req, halt_req, clr_req;
    assign stall_req  = (Stall === 1'b1) || (LoadUseStall === 1'b1);
    assign two_cycle  = (Stall === 1'b1) && (StallWrite === 1'b1);
    assign branch_req = (BranchTaken === 1'b1);
    assign halt_req   = (Hlt === 1'b1);
    assign clr_req    = (StatClr === 1'b1);

    always_comb begin
        PC_Wr       = 1'b1;
        IFID_Wr     = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        Busy        = 1'b0;
        if (!rst_n) begin
            PC_Wr       = 1'b0;
            IFID_Wr     = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (stall_req) begin
                        PC_Wr       = 1'b0;
                        IFID_Wr     = 1'b0;
                        IDEX_Bubble = 1'b1;
                        Busy        = 1'b1;
                    end else if (branch_req) begin
                        IFID_Flush = 1'b1;
                    end else if (halt_req) begin
                        PC_Wr   = 1'b0;
                        IFID_Wr = 1'b0;
                    end
                end
                STALL: begin
                    PC_Wr       = 1'b0;
                    IFID_Wr     = 1'b0;
                    IDEX_Bubble = 1'b1;
                    Busy        = 1'b1;
                end
                default: begin
                    PC_Wr       = 1'b0;
                    IFID_Wr     = 1'b0;
                    IDEX_Bubble = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            rem    <= 1'b0;
            Halted <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (stall_req) begin
                        if (two_cycle) begin
                            state <= STALL;
                            rem   <= 1'b0;
                        end
                    end else if (!branch_req && halt_req) begin
                        state  <= HALTED;
                        Halted <= 1'b1;
                    end
                end
                STALL: begin
                    if (rem == 1'b0) state <= RUN;
                    else             rem   <= rem - 1'b1;
                end
                HALTED: state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    // Clear beats increment; the counter sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCycles <= '0;
        end else if (clr_req) begin
            StallCycles <= '0;
        end else if (Busy && (StallCycles != {CNT_W{1'b1}})) begin
            StallCycles <= StallCycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_stall_flush_sequencer.sv
// Bench for stall_flush_sequencer: directed vector table, hand-written reset/saturation
// sequences and random traffic against a cycle-level behavioural model.
module tb_stall_flush_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0, stall_write = 1'b0, load_use = 1'b0;
    logic branch = 1'b0, hlt = 1'b0, stat_clr = 1'b0;

    logic pc_wr, ifid_wr, ifid_flush, idex_bubble, busy, halted;
    logic pc_wr4, ifid_wr4, ifid_flush4, idex_bubble4, busy4, halted4;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    stall_flush_sequencer #(.CNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .Stall(stall), .StallWrite(stall_write),
        .LoadUseStall(load_use), .BranchTaken(branch), .Hlt(hlt), .StatClr(stat_clr),
        .PC_Wr(pc_wr), .IFID_Wr(ifid_wr), .IFID_Flush(ifid_flush), .IDEX_Bubble(idex_bubble),
        .Busy(busy), .Halted(halted), .StallCycles(cnt16)
    );

    stall_flush_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .Stall(stall), .StallWrite(stall_write),
        .LoadUseStall(load_use), .BranchTaken(branch), .Hlt(hlt), .StatClr(stat_clr),
        .PC_Wr(pc_wr4), .IFID_Wr(ifid_wr4), .IFID_Flush(ifid_flush4), .IDEX_Bubble(idex_bubble4),
        .Busy(busy4), .Halted(halted4), .StallCycles(cnt4)
    );

    typedef struct {
        logic pc, ifid, flush, bub, busy, halt;
        int   cnt16, cnt4;
    } exp_t;

    // inputs packed as {stall, stall_write, load_use, branch, hlt, stat_clr}
    typedef struct {
        logic [5:0] in;
        logic       pc, ifid, flush, bub, busy, halt;
        int         cnt;
    } vec_t;

    // Behavioural model: stalled cycles still owed, halt flag, two counters.
    int m_left = 0;
    bit m_halted = 0;
    int m_cnt16 = 0, m_cnt4 = 0;

    task automatic model_reset();
        m_left = 0; m_halted = 0; m_cnt16 = 0; m_cnt4 = 0;
    endtask

    task automatic model_cycle(input logic [5:0] in, output exp_t e);
        bit s, sw, lu, br, h, c;
        s = (in[5] === 1'b1); sw = (in[4] === 1'b1); lu = (in[3] === 1'b1);
        br = (in[2] === 1'b1); h = (in[1] === 1'b1); c = (in[0] === 1'b1);
        e.halt = m_halted; e.cnt16 = m_cnt16; e.cnt4 = m_cnt4;
        e.pc = 1; e.ifid = 1; e.flush = 0; e.bub = 0; e.busy = 0;
        if (m_halted) begin
            e.pc = 0; e.ifid = 0; e.bub = 1;
        end else if (m_left > 0) begin
            e.pc = 0; e.ifid = 0; e.bub = 1; e.busy = 1;
            m_left = m_left - 1;
        end else if (s || lu) begin
            e.pc = 0; e.ifid = 0; e.bub = 1; e.busy = 1;
            if (s && sw) m_left = 1;
        end else if (br) begin
            e.flush = 1;
        end else if (h) begin
            e.pc = 0; e.ifid = 0;
            m_halted = 1;
        end
        if (c) begin
            m_cnt16 = 0; m_cnt4 = 0;
        end else if (e.busy) begin
            m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
            m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
        end
    endtask

    task automatic check(input string tag, input exp_t e);
        logic [5:0] act, req;
        act = {pc_wr, ifid_wr, ifid_flush, idex_bubble, busy, halted};
        req = {e.pc, e.ifid, e.flush, e.bub, e.busy, e.halt};
        total++;
        if (act !== req || cnt16 !== 16'(e.cnt16) || cnt4 !== 4'(e.cnt4)) begin
            bad++;
            $display("FAIL %s t=%0t ctl{pc,ifid,flush,bub,busy,halt} got=%b want=%b cnt16 got=%0d want=%0d cnt4 got=%0d want=%0d",
                     tag, $time, act, req, cnt16, e.cnt16, cnt4, e.cnt4);
        end
    endtask

    task automatic drive(input logic [5:0] in);
        {stall, stall_write, load_use, branch, hlt, stat_clr} = in;
    endtask

    function automatic exp_t forced_exp();
        exp_t e;
        e.pc = 0; e.ifid = 0; e.flush = 1; e.bub = 1; e.busy = 0; e.halt = 0;
        e.cnt16 = 0; e.cnt4 = 0;
        return e;
    endfunction

    // One clock: drive after the edge, model, sample on the falling edge.
    task automatic run_cycle(input logic [5:0] in, input string tag);
        exp_t e;
        @(posedge clk); #1;
        drive(in);
        model_cycle(in, e);
        @(negedge clk);
        check(tag, e);
    endtask

    vec_t vecs[19];

    initial begin
        exp_t e;
        int halt_cycles;

        //            in(s,sw,lu,br,h,c) pc ifid fl bub busy halt cnt
        vecs[0]  = '{6'b000000, 1, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{6'b110000, 0, 0, 0, 1, 1, 0, 0};
        vecs[2]  = '{6'b100000, 0, 0, 0, 1, 1, 0, 1};
        vecs[3]  = '{6'b000001, 1, 1, 0, 0, 0, 0, 2};
        vecs[4]  = '{6'b001000, 0, 0, 0, 1, 1, 0, 0};
        vecs[5]  = '{6'b001000, 0, 0, 0, 1, 1, 0, 1};
        vecs[6]  = '{6'b001000, 0, 0, 0, 1, 1, 0, 2};
        vecs[7]  = '{6'b000001, 1, 1, 0, 0, 0, 0, 3};
        vecs[8]  = '{6'b100100, 0, 0, 0, 1, 1, 0, 0};
        vecs[9]  = '{6'b000100, 1, 1, 1, 0, 0, 0, 1};
        vecs[10] = '{6'b100000, 0, 0, 0, 1, 1, 0, 1};
        vecs[11] = '{6'b000000, 1, 1, 0, 0, 0, 0, 2};
        vecs[12] = '{6'b110100, 0, 0, 0, 1, 1, 0, 2};
        vecs[13] = '{6'b000110, 0, 0, 0, 1, 1, 0, 3};
        vecs[14] = '{6'b001010, 0, 0, 0, 1, 1, 0, 4};
        vecs[15] = '{6'b000010, 0, 0, 0, 0, 0, 0, 5};
        vecs[16] = '{6'b000100, 0, 0, 0, 1, 0, 1, 5};
        vecs[17] = '{6'b110000, 0, 0, 0, 1, 0, 1, 5};
        vecs[18] = '{6'b001000, 0, 0, 0, 1, 0, 1, 5};

        // Reset held for three cycles
        drive(6'b000000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("in_reset_%0d", i), forced_exp());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();

        // Directed table (model cross-checked too)
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].in);
            model_cycle(vecs[i].in, e);
            @(negedge clk);
            e.pc = vecs[i].pc; e.ifid = vecs[i].ifid; e.flush = vecs[i].flush;
            e.bub = vecs[i].bub; e.busy = vecs[i].busy; e.halt = vecs[i].halt;
            e.cnt16 = vecs[i].cnt; e.cnt4 = vecs[i].cnt;
            check($sformatf("vec_%0d", i), e);
        end

        // Asynchronous reset out of HALTED, mid-cycle
        #1;
        rst_n = 1'b0;
        #1;
        check("halted_async_reset", forced_exp());
        #2;
        rst_n = 1'b1;
        model_reset();
        drive(6'b000000);
        run_cycle(6'b000000, "after_halt_reset");

        // Reset during the STALL cycle discards the remaining stall
        run_cycle(6'b110000, "stall_req_before_reset");
        @(posedge clk); #1;
        drive(6'b000000);
        rst_n = 1'b0;
        #1;
        check("stall_async_reset", forced_exp());
        #2;
        rst_n = 1'b1;
        model_reset();
        model_cycle(6'b000000, e);
        @(negedge clk);
        check("run_after_stall_reset", e);

        // X on a request reads as deasserted
        @(posedge clk); #1;
        drive(6'b000000);
        stall = 1'bx;
        load_use = 1'bz;
        model_cycle(6'b000000, e);
        @(negedge clk);
        check("x_inputs_ignored", e);

        // Saturation: 20 stalled cycles after a clear
        run_cycle(6'b000001, "sat_clear");
        for (int i = 0; i < 20; i++) run_cycle(6'b001000, $sformatf("sat_%0d", i));
        run_cycle(6'b000000, "sat_final");
        total++;
        if (cnt4 !== 4'd15 || cnt16 !== 16'd20) begin
            bad++;
            $display("FAIL saturation cnt4 got=%0d want=15 cnt16 got=%0d want=20", cnt4, cnt16);
        end

        // Random traffic against the model; reset the core a few cycles after it halts
        halt_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] in;
            in[5] = ($urandom_range(0, 3) == 0);
            in[4] = $urandom_range(0, 1);
            in[3] = ($urandom_range(0, 4) == 0);
            in[2] = ($urandom_range(0, 4) == 0);
            in[1] = ($urandom_range(0, 49) == 0);
            in[0] = ($urandom_range(0, 29) == 0);
            if (m_halted) halt_cycles++;
            if (halt_cycles > 4) begin
                halt_cycles = 0;
                @(posedge clk); #1;
                drive(6'b000000);
                rst_n = 1'b0;
                @(negedge clk);
                check($sformatf("rand_reset_%0d", i), forced_exp());
                @(posedge clk); #1;
                rst_n = 1'b1;
                model_reset();
                @(negedge clk);
            end
            run_cycle(in, $sformatf("rand_%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
